// File: rtl/sc_spi_xfer_buf_if.sv
// sc_spi_xfer_buf_if
//   Bundles the host register-file port and the SPI engine port of the
//   transfer buffer. SPICLK and SYSRSTB stay outside as plain module ports.
//
//   Host side : TXWE/TXWADDR/TXWDATA (TX buffer write), RXRADDR/RXRDATA
//               (registered RX read), GO/BUSY/DONE/GOERR (transfer control),
//               TXCNT/RXCNT/RXOVF (progress status).
//   Engine    : SPISTART/SPIBUSY (start handshake), TXDPT/TXDATA (TX word
//               select), TXDETECT (TX latch toggle), RXVALID/RXDATA (RX word
//               toggle and data).
//   Debug     : FSM_STATE exposes the sequencer state.
//
//   slave  modport : the buffer itself.
//   master modport : whatever drives the host and engine inputs.
interface sc_spi_xfer_buf_if;
   logic        TXWE;
   logic [3:0]  TXWADDR;
   logic [31:0] TXWDATA;
   logic [3:0]  RXRADDR;
   logic [31:0] RXRDATA;
   logic        GO;
   logic        BUSY;
   logic        DONE;
   logic        GOERR;
   logic [4:0]  TXCNT;
   logic [4:0]  RXCNT;
   logic        RXOVF;
   logic        SPISTART;
   logic        SPIBUSY;
   logic [3:0]  TXDPT;
   logic [31:0] TXDATA;
   logic        TXDETECT;
   logic        RXVALID;
   logic [31:0] RXDATA;
   logic [1:0]  FSM_STATE;

   modport slave (
      input  TXWE, TXWADDR, TXWDATA, RXRADDR, GO, SPIBUSY, TXDPT,
             TXDETECT, RXVALID, RXDATA,
      output RXRDATA, BUSY, DONE, GOERR, TXCNT, RXCNT, RXOVF, SPISTART,
             TXDATA, FSM_STATE
   );

   modport master (
      output TXWE, TXWADDR, TXWDATA, RXRADDR, GO, SPIBUSY, TXDPT,
             TXDETECT, RXVALID, RXDATA,
      input  RXRDATA, BUSY, DONE, GOERR, TXCNT, RXCNT, RXOVF, SPISTART,
             TXDATA, FSM_STATE
   );
endinterface

// File: rtl/sc_spi_xfer_buf.sv
// sc_spi_xfer_buf
//   SPICLK-domain transfer buffer and start sequencer next to the SPI
//   protocol controller. Holds 16 x 32-bit TX words selected by the engine's
//   TXDPT, captures up to 16 RX words (one per RXVALID toggle), and runs one
//   SPISTART/SPIBUSY handshake per accepted host GO.
//
//   Ports:
//     SPICLK  - engine clock
//     SYSRSTB - asynchronous active-low reset
//     bus     - sc_spi_xfer_buf_if.slave (host port, engine port, FSM_STATE)
//
//   Start handshake: SPISTART is a request held high from GO acceptance
//   until SPIBUSY is seen high; SPIBUSY high is the engine's acknowledge and
//   also marks the transfer in progress. The transfer completes when SPIBUSY
//   returns low. SPISTART and SPIBUSY overlap for one cycle, which the engine
//   ignores because it is already busy.
module sc_spi_xfer_buf (
   input  logic                    SPICLK,
   input  logic                    SYSRSTB,
   sc_spi_xfer_buf_if.slave        bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_CMPL = 2'd3;

   logic [1:0]  state;
   logic [31:0] txmem [16];
   logic [31:0] rxmem [16];
   logic        txdet_d;
   logic        rxval_d;
   logic        tx_ev;
   logic        rx_ev;
   logic        go_ok;
   logic        rx_wr;
   logic [4:0]  txcnt;
   logic [4:0]  rxcnt;
   logic        rxovf;
   logic [31:0] rxrdata;
   logic        spistart;
   logic        busy;
   logic        done;
   logic        goerr;

   assign tx_ev = bus.TXDETECT ^ txdet_d;
   assign rx_ev = bus.RXVALID ^ rxval_d;
   assign go_ok = bus.GO && (state == ST_IDLE);
   // An accepted GO clears the counters; an RX event in that same cycle is
   // discarded entirely, including its buffer write.
   assign rx_wr = rx_ev && !rxcnt[4] && !go_ok;

   // Buffers are plain storage: not reset, not cleared by GO.
   always_ff @(posedge SPICLK) begin
      if (bus.TXWE)
         txmem[bus.TXWADDR] <= bus.TXWDATA;
   end

   always_ff @(posedge SPICLK) begin
      if (rx_wr)
         rxmem[rxcnt[3:0]] <= bus.RXDATA;
   end

   assign bus.TXDATA = txmem[bus.TXDPT];

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         state    <= ST_IDLE;
         txdet_d  <= 1'b0;
         rxval_d  <= 1'b0;
         txcnt    <= 5'd0;
         rxcnt    <= 5'd0;
         rxovf    <= 1'b0;
         rxrdata  <= 32'd0;
         spistart <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         goerr    <= 1'b0;
      end else begin
         txdet_d <= bus.TXDETECT;
         rxval_d <= bus.RXVALID;
         // Read-before-write: a same-address RX capture returns old data.
         rxrdata <= rxmem[bus.RXRADDR];
         done    <= 1'b0;
         goerr   <= bus.GO && (state != ST_IDLE);

         if (go_ok) begin
            txcnt <= 5'd0;
            rxcnt <= 5'd0;
            rxovf <= 1'b0;
         end else begin
            if (tx_ev && (txcnt != 5'd16))
               txcnt <= txcnt + 5'd1;
            if (rx_ev) begin
               if (rxcnt[4])
                  rxovf <= 1'b1;
               else
                  rxcnt <= rxcnt + 5'd1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (bus.GO) begin
                  state    <= ST_REQ;
                  spistart <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_REQ: begin
               if (bus.SPIBUSY) begin
                  state    <= ST_RUN;
                  spistart <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!bus.SPIBUSY)
                  state <= ST_CMPL;
            end
            ST_CMPL: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.TXCNT     = txcnt;
   assign bus.RXCNT     = rxcnt;
   assign bus.RXOVF     = rxovf;
   assign bus.RXRDATA   = rxrdata;
   assign bus.SPISTART  = spistart;
   assign bus.BUSY      = busy;
   assign bus.DONE      = done;
   assign bus.GOERR     = goerr;
   assign bus.FSM_STATE = state;

endmodule
